reglk_seq_ctrl: RTL and testbench

- Parametrised register-lock sequencer on the peripheral REG_BUS.
- Software stages NUM_LOCKS lock bytes, then commits them atomically into the reglk_ctrl_o vector that drives the SoC register-lock fabric.
- Committed lock bits are sticky. They can only be cleared by a commit issued with the correct unlock key.
- Successor to the single-byte test lock block: adds channel count, a key-protected clear, an abort command, a status register and optional load timeout.

---
 rtl/reglk_seq_ctrl_if.sv | 25 ++
 rtl/reglk_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_reglk_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reglk_seq_ctrl_if.sv
// Peripheral register bus shared by the lock sequencer and its host.
// Single-cycle: slave answers combinationally with ready/error.
interface REG_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    error;

  modport in (
    input  addr, write, wdata, wstrb, valid,
    output rdata, ready, error
  );

  modport out (
    output addr, write, wdata, wstrb, valid,
    input  rdata, ready, error
  );
endinterface

// File: rtl/reglk_seq_ctrl.sv
// Register-lock sequencer: stages lock bytes, commits them into reglk_ctrl_o.
// Define REGLK_TIMEOUT_EN to auto-abort an idle LOAD after TIMEOUT_CYCLES.
module reglk_seq_ctrl #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_LOCKS      = 4,
  parameter logic [31:0] UNLOCK_KEY     = 32'hA5C3_5A3C,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [8*NUM_LOCKS-1:0] reglk_ctrl_o,
  REG_BUS.in                     external_bus_io
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    COMMIT = 3'd2,
    DONE   = 3'd3
  } state_t;

  localparam int CW = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    live  [NUM_LOCKS];
  logic [7:0]    stage [NUM_LOCKS];
  logic [31:0]   key;
  logic          err;
  logic          tmo;
  logic [7:0]    cnt;
  logic [CW-1:0] ch;
  logic [6:0]    idx;
  logic          wr;
  logic          cmd_start;
  logic          cmd_commit;
  logic          cmd_abort;
  logic          to_abort;
  logic          last_ch;
  logic          is_stage;
  logic          is_live;
  logic [7:0]    stage_rd;
  logic [7:0]    live_rd;
  logic [31:0]   rd;

  logic [ADDR_WIDTH-1:0]   unused_addr;
  logic [DATA_WIDTH/8-1:0] unused_wstrb;
  assign unused_addr  = external_bus_io.addr;
  assign unused_wstrb = external_bus_io.wstrb;

  assign idx = external_bus_io.addr[8:2];
  assign wr  = external_bus_io.valid & external_bus_io.write;

  assign cmd_start  = wr && idx == 7'd0 &&
                      external_bus_io.wdata == DATA_WIDTH'(1);
  assign cmd_commit = wr && idx == 7'd0 &&
                      external_bus_io.wdata == DATA_WIDTH'(2);
  assign cmd_abort  = wr && idx == 7'd0 &&
                      external_bus_io.wdata == DATA_WIDTH'(3);
  assign last_ch    = ch == CW'(NUM_LOCKS - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (cmd_start) state_nx = LOAD;
      LOAD: begin
        if (cmd_commit)                 state_nx = COMMIT;
        else if (cmd_abort || to_abort) state_nx = IDLE;
      end
      COMMIT: if (last_ch) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        live[i]  <= '0;
        stage[i] <= '0;
      end
      key <= '0;
      err <= 1'b0;
      cnt <= '0;
      ch  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (cmd_start) begin
            stage <= live;
            err   <= 1'b0;
          end else if (wr) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          if (wr && idx == 7'd2) key <= 32'(external_bus_io.wdata);
          for (int i = 0; i < NUM_LOCKS; i++)
            if (wr && int'(idx) == 3 + i)
              stage[i] <= external_bus_io.wdata[7:0];
          if (cmd_commit) ch <= '0;
          if (cmd_abort || to_abort) key <= '0;
        end
        COMMIT: begin
          // A wrong key can only add lock bits; attempted clears flag err.
          if (key == UNLOCK_KEY) begin
            live[ch] <= stage[ch];
          end else begin
            live[ch] <= live[ch] | stage[ch];
            if ((live[ch] & ~stage[ch]) != 8'h00) err <= 1'b1;
          end
          if (wr) err <= 1'b1;
          ch <= last_ch ? '0 : ch + 1'b1;
          if (last_ch) begin
            key <= '0;
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reglk_ctrl_o <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++)
        reglk_ctrl_o[8*i +: 8] <= live[i];
    end
  end

`ifdef REGLK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign to_abort = state == LOAD && !wr &&
                    tcnt == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      if (state != LOAD || wr || to_abort) tcnt <= '0;
      else                                 tcnt <= tcnt + 1'b1;
      if (to_abort)
        tmo <= 1'b1;
      else if (cmd_start && (state == IDLE || state == DONE))
        tmo <= 1'b0;
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = TIMEOUT_CYCLES != 0;
  assign to_abort       = 1'b0;
  assign tmo            = 1'b0;
`endif

  always_comb begin
    is_stage = 1'b0;
    is_live  = 1'b0;
    stage_rd = '0;
    live_rd  = '0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      if (int'(idx) == 3 + i) begin
        is_stage = 1'b1;
        stage_rd = stage[i];
      end
      if (int'(idx) == 3 + NUM_LOCKS + i) begin
        is_live = 1'b1;
        live_rd = live[i];
      end
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      idx == 7'd1: rd = {16'h0, cnt, 3'b0, tmo, err, state};
      is_stage:    rd = {24'h0, stage_rd};
      is_live:     rd = {24'h0, live_rd};
      default:     rd = '0;
    endcase
  end

  assign external_bus_io.rdata = DATA_WIDTH'(rd);
  assign external_bus_io.ready = 1'b1;
  assign external_bus_io.error = 1'b0;

endmodule

// File: tb/tb_reglk_seq_ctrl.sv
// Scoreboard bench for reglk_seq_ctrl: directed sequences then random traffic
// against a transaction-level lock model.
module tb_reglk_seq_ctrl;
  localparam int          NL   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] KEYV = 32'hA5C3_5A3C;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [8*NL-1:0] reglk;
  logic          probe = 1'b0;

  REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  reglk_seq_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_LOCKS(NL),
    .UNLOCK_KEY(KEYV),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .reglk_ctrl_o(reglk),
    .external_bus_io(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_out;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int checks   = 0;
  int failures = 0;

  // reference model
  logic [7:0]  m_live  [NL];
  logic [7:0]  m_stage [NL];
  logic [31:0] m_key;
  logic [2:0]  m_state;
  logic        m_err;
  logic        m_tmo;
  logic [7:0]  m_cnt;
  int          m_ch;
  int          m_idle;
  logic [31:0] m_out;

  task automatic m_reset();
    for (int i = 0; i < NL; i++) begin
      m_live[i]  = 8'h00;
      m_stage[i] = 8'h00;
    end
    m_key = 0; m_state = 3'd0; m_err = 0; m_tmo = 0;
    m_cnt = 0; m_ch = 0; m_idle = 0; m_out = 0;
  endtask

  function automatic logic [31:0] m_read(int idx);
    if (idx == 1)
      return {16'h0, m_cnt, 3'b0, m_tmo, m_err, m_state};
    if (idx >= 3 && idx < 3 + NL)
      return {24'h0, m_stage[idx-3]};
    if (idx >= 3 + NL && idx < 3 + 2*NL)
      return {24'h0, m_live[idx-3-NL]};
    return 32'h0;
  endfunction

  // Effect of one clock edge on the model, given the bus cycle just issued.
  task automatic m_step(bit w, int idx, logic [31:0] d);
    logic [31:0] out_n;
    if (!rst_n) return;
    for (int i = 0; i < NL; i++) out_n[8*i +: 8] = m_live[i];
    case (m_state)
      3'd0, 3'd3: begin
        if (w && idx == 0 && d == 1) begin
          for (int i = 0; i < NL; i++) m_stage[i] = m_live[i];
          m_err = 0; m_tmo = 0; m_idle = 0; m_state = 3'd1;
        end else if (w) begin
          m_err = 1;
        end
      end
      3'd1: begin
        if (w) begin
          m_idle = 0;
          if (idx == 2) m_key = d;
          if (idx >= 3 && idx < 3 + NL) m_stage[idx-3] = d[7:0];
          if (idx == 0 && d == 2) begin
            m_state = 3'd2; m_ch = 0;
          end else if (idx == 0 && d == 3) begin
            m_state = 3'd0; m_key = 0;
          end
        end else begin
`ifdef REGLK_TIMEOUT_EN
          m_idle++;
          if (m_idle == TO) begin
            m_state = 3'd0; m_key = 0; m_tmo = 1; m_idle = 0;
          end
`endif
        end
      end
      3'd2: begin
        if (w) m_err = 1;
        if (m_key == KEYV) begin
          m_live[m_ch] = m_stage[m_ch];
        end else begin
          if ((m_live[m_ch] & ~m_stage[m_ch]) != 0) m_err = 1;
          m_live[m_ch] = m_live[m_ch] | m_stage[m_ch];
        end
        m_ch++;
        if (m_ch == NL) begin
          m_key = 0; m_cnt = m_cnt + 8'd1; m_state = 3'd3;
        end
      end
      default: ;
    endcase
    m_out = out_n;
  endtask

  // stimulus: each task starts and ends 1 time unit after a posedge
  task automatic txn(bit w, int idx, logic [31:0] d);
    item_t it;
    bus.valid = 1'b1;
    bus.write = w;
    bus.addr  = 32'(idx) << 2;
    bus.wdata = d;
    bus.wstrb = 4'hF;
    if (!w) begin
      it.is_out = 0;
      it.exp    = m_read(idx);
      it.name   = $sformatf("rd_idx%0d", idx);
      sbq.push_back(it);
    end
    @(posedge clk);
    m_step(w, idx, d);
    #1;
    bus.valid = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic wr(int idx, logic [31:0] d);
    txn(1'b1, idx, d);
  endtask

  task automatic rd(int idx);
    txn(1'b0, idx, 32'h0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_step(1'b0, 0, 32'h0);
      #1;
    end
  endtask

  task automatic chk_out(string name);
    item_t it;
    it.is_out = 1;
    it.exp    = m_out;
    it.name   = name;
    sbq.push_back(it);
    probe = 1'b1;
    @(posedge clk);
    m_step(1'b0, 0, 32'h0);
    #1;
    probe = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    if ((bus.valid && !bus.write) || probe) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_empty got=output exp=queued_item");
      end else begin
        it  = sbq.pop_front();
        act = it.is_out ? 32'(reglk) : bus.rdata;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    bus.valid = 0; bus.write = 0; bus.addr = 0;
    bus.wdata = 0; bus.wstrb = 0;
    m_reset();

    // reset values while held and after release
    @(posedge clk); #1;
    chk_out("out_in_rst");
    rd(1); rd(3 + NL);
    rst_n = 1'b1;
    rd(1);
    for (int i = 0; i < NL; i++) rd(3 + NL + i);
    chk_out("out_after_rst");

    // first commit with zero key; STATUS polled through completion
    wr(0, 1); wr(3, 32'h81); wr(6, 32'hFF); wr(2, 0);
    wr(0, 2);
    repeat (NL + 1) rd(1);
    chk_out("out_commit1");
    rd(1);

    // attempted clear with wrong key, then with unlock key
    wr(0, 1); wr(3, 32'h01); wr(2, 0); wr(0, 2);
    idle(NL);
    rd(3 + NL); rd(1);
    wr(0, 1); wr(3, 32'h01); wr(2, KEYV); rd(2); wr(0, 2);
    idle(NL);
    rd(3 + NL); rd(1); rd(2);
    chk_out("out_unlock");

    // abort keeps live, stage write in IDLE flags err
    wr(0, 1); wr(4, 32'h55); wr(0, 3);
    rd(1); rd(4 + NL);
    wr(5, 32'h12);
    rd(1); rd(5);

    // write during commit, then async reset mid-commit
    wr(0, 1); wr(4, 32'h0F); wr(5, 32'hF0); wr(0, 2);
    wr(5, 32'hAA);
    rd(1); rd(4 + NL);
    @(posedge clk); #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_out("out_mid_rst");
    rd(1); rd(4 + NL);
    rst_n = 1'b1;
    rd(1);

    // idle LOAD: times out only when enabled
    wr(0, 1);
    idle(TO - 1);
    rd(1);
    rd(1);
    idle(100);
    rd(1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    wr(0, 32'($urandom_range(0, 4)));
        2:       wr(2, ($urandom_range(0, 1) != 0) ? KEYV : $urandom);
        3, 4:    wr($urandom_range(1, 3 + 2*NL + 1), $urandom);
        5, 6, 7: rd($urandom_range(0, 3 + 2*NL + 2));
        8:       chk_out("out_rand");
        default: idle($urandom_range(1, 6));
      endcase
    end

    idle(2);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
